// File: rtl/seq_gen.sv
// Parallel-to-serial stimulus generator: serializes WIDTH-bit words MSB first with optional gaps and repeat.
// Optional feature: define SEQ_GEN_PARITY_EN to append an even-parity bit after each word.
module seq_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 0
) (
  input  logic             clk,
  input  logic             r,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             rep,
  output logic             ready,
  output logic             d,
  output logic             valid,
  output logic [7:0]       words
);

`ifdef SEQ_GEN_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned NB = WIDTH + PAR;
  localparam int unsigned CW = $clog2(NB);
  localparam int unsigned GW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t          state;
  logic [NB-1:0]   sr;
  logic [WIDTH-1:0] saved;
  logic [CW-1:0]   cnt;
  logic [GW-1:0]   gcnt;

  logic             last_bit;
  logic             last_gap;
  logic             decide;
  logic             reload;
  logic             start;
  logic [WIDTH-1:0] start_word;
  logic [NB-1:0]    start_frame;

  // Serial frame for a word: the word itself, plus its parity bit when enabled.
  function automatic logic [NB-1:0] frame(input logic [WIDTH-1:0] w);
`ifdef SEQ_GEN_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  // Word-end decision point: last frame bit without gap, or last gap cycle.
  assign last_bit    = (state == ST_SHIFT) && (cnt == CW'(NB - 1));
  assign last_gap    = (state == ST_GAP) && (gcnt == GW'(GAP - 1));
  assign decide      = ((GAP == 0) && last_bit) || last_gap;
  assign reload      = decide && rep;
  assign ready       = (state == ST_IDLE) || (decide && !rep);
  assign start       = reload || (ready && load);
  assign start_word  = reload ? saved : din;
  assign start_frame = frame(start_word);

  // Current bit is always the shift-register MSB; it is zero outside SHIFT.
  assign d = sr[NB-1];

  always_ff @(posedge clk) begin
    if (r) begin
      state <= ST_IDLE;
      sr    <= '0;
      saved <= '0;
      cnt   <= '0;
      gcnt  <= '0;
      valid <= 1'b0;
      words <= 8'd0;
    end else begin
      unique case (state)
        ST_SHIFT: begin
          sr  <= sr << 1;
          cnt <= cnt + CW'(1);
          if (last_bit) begin
            words <= words + 8'd1;
            if (GAP != 0) begin
              state <= ST_GAP;
              gcnt  <= '0;
              valid <= 1'b0;
            end
          end
        end
        ST_GAP:  gcnt <= gcnt + GW'(1);
        default: ;
      endcase

      // Reload/accept overrides the per-state updates above.
      if (start) begin
        state <= ST_SHIFT;
        sr    <= start_frame;
        saved <= start_word;
        cnt   <= '0;
        valid <= 1'b1;
      end else if (decide) begin
        state <= ST_IDLE;
        sr    <= '0;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: word-level reference model compared every cycle, plus directed literals.
module tb_seq_gen;

  localparam int W = 8;
`ifdef SEQ_GEN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = W + PAR;

  logic       clk = 1'b0;
  logic       r = 1'b1;
  logic       load = 1'b0;
  logic       rep = 1'b0;
  logic [7:0] din = 8'h00;

  logic       ready0, d0, valid0, ready3, d3, valid3;
  logic [7:0] words0, words3;

  always #5 clk = ~clk;

  seq_gen #(.WIDTH(W), .GAP(0)) dut0 (
    .clk(clk), .r(r), .load(load), .din(din), .rep(rep),
    .ready(ready0), .d(d0), .valid(valid0), .words(words0)
  );

  seq_gen #(.WIDTH(W), .GAP(3)) dut3 (
    .clk(clk), .r(r), .load(load), .din(din), .rep(rep),
    .ready(ready3), .d(d3), .valid(valid3), .words(words3)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame bits still to emit, gap cycles still to wait, saved word, word count.
  int          nb_left [2];
  int          gap_left[2];
  logic [31:0] frm     [2];
  logic [7:0]  saved   [2];
  logic [7:0]  mwords  [2];

  function automatic int gapv(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] mk_frame(input logic [7:0] w);
`ifdef SEQ_GEN_PARITY_EN
    return 32'({w, ^w});
`else
    return 32'(w);
`endif
  endfunction

  task automatic m_start(input int k, input logic [7:0] w);
    saved[k]   = w;
    frm[k]     = mk_frame(w);
    nb_left[k] = NB;
  endtask

  task automatic m_decide(input int k);
    if (rep) m_start(k, saved[k]);
    else if (load) m_start(k, din);
  endtask

  task automatic m_step(input int k);
    if (r) begin
      nb_left[k] = 0; gap_left[k] = 0; saved[k] = 8'h00; mwords[k] = 8'h00; frm[k] = 0;
    end else if (nb_left[k] > 0) begin
      nb_left[k]--;
      if (nb_left[k] == 0) begin
        mwords[k] = mwords[k] + 8'd1;
        if (gapv(k) > 0) gap_left[k] = gapv(k);
        else m_decide(k);
      end
    end else if (gap_left[k] > 0) begin
      gap_left[k]--;
      if (gap_left[k] == 0) m_decide(k);
    end else if (load) begin
      m_start(k, din);
    end
  endtask

  function automatic logic m_d(input int k);
    if (nb_left[k] > 0) return frm[k][nb_left[k]-1];
    return 1'b0;
  endfunction

  function automatic logic m_ready(input int k);
    return (nb_left[k] == 0 && gap_left[k] == 0) ||
           (nb_left[k] == 1 && gapv(k) == 0 && !rep) ||
           (nb_left[k] == 0 && gap_left[k] == 1 && !rep);
  endfunction

  always @(posedge clk) begin
    m_step(0);
    m_step(1);
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("g0_d",     32'(d0),     32'(m_d(0)));
      chk("g0_valid", 32'(valid0), 32'(nb_left[0] > 0));
      chk("g0_ready", 32'(ready0), 32'(m_ready(0)));
      chk("g0_words", 32'(words0), 32'(mwords[0]));
      chk("g3_d",     32'(d3),     32'(m_d(1)));
      chk("g3_valid", 32'(valid3), 32'(nb_left[1] > 0));
      chk("g3_ready", 32'(ready3), 32'(m_ready(1)));
      chk("g3_words", 32'(words3), 32'(mwords[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    r = 1'b1;
    tick();
    r = 1'b0;
  endtask

`ifdef SEQ_GEN_PARITY_EN
  localparam logic [31:0] E_SINGLE = 32'({8'hD4, 1'b0});
  localparam logic [31:0] E_B2B    = 32'({8'hA5, 1'b0, 8'h3C, 1'b0});
  localparam logic [31:0] E_REP    = 32'({8'h81, 1'b0, 8'h81, 1'b0});
  localparam logic [31:0] E_VPAT   = 32'h0000_0FF8;
  localparam logic [31:0] E_DPAT   = 32'h0000_0F00;
`else
  localparam logic [31:0] E_SINGLE = 32'h0000_00D4;
  localparam logic [31:0] E_B2B    = 32'h0000_A53C;
  localparam logic [31:0] E_REP    = 32'h0000_8181;
  localparam logic [31:0] E_VPAT   = 32'h0000_07F8;
  localparam logic [31:0] E_DPAT   = 32'h0000_0780;
`endif

  logic [31:0] acc, vpat, dpat;
  int          nv, nr;

  initial begin
    // Reset held two cycles, then idle.
    r = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("idle_ready", 32'(ready0), 32'd1);
      chk("idle_valid", 32'(valid0), 32'd0);
      chk("idle_d",     32'(d0),     32'd0);
      chk("idle_words", 32'(words0), 32'd0);
      tick();
    end

    // Single word.
    din = 8'hD4; load = 1'b1; tick(); load = 1'b0;
    acc = 0; nv = 0;
    for (int i = 0; i < NB; i++) begin
      acc = {acc[30:0], d0}; nv += int'(valid0); tick();
    end
    chk("single_bits",   acc,           E_SINGLE);
    chk("single_nvalid", 32'(nv),       32'(NB));
    chk("single_words",  32'(words0),   32'd1);
    chk("single_idle",   32'(valid0),   32'd0);

    // Back-to-back words, second load presented during the last bit.
    do_reset();
    din = 8'hA5; load = 1'b1; tick(); load = 1'b0;
    acc = 0; nv = 0;
    for (int i = 0; i < 2 * NB; i++) begin
      acc = {acc[30:0], d0}; nv += int'(valid0);
      if (i == NB - 1) begin
        chk("b2b_ready_last", 32'(ready0), 32'd1);
        din = 8'h3C; load = 1'b1;
      end
      tick(); load = 1'b0;
    end
    chk("b2b_bits",   acc,         E_B2B);
    chk("b2b_nvalid", 32'(nv),     32'(2 * NB));
    chk("b2b_words",  32'(words0), 32'd2);

    // Gap of 3 with repeat.
    do_reset();
    rep = 1'b1; din = 8'hF0; load = 1'b1; tick(); load = 1'b0;
    vpat = 0; dpat = 0; nv = 0; nr = 0;
    for (int i = 0; i < 3 * (NB + 3); i++) begin
      if (i < NB + 3) begin
        vpat = {vpat[30:0], valid3}; dpat = {dpat[30:0], d3};
      end
      nv += int'(valid3); nr += int'(ready3); tick();
    end
    chk("gap_vpat",   vpat,        E_VPAT);
    chk("gap_dpat",   dpat,        E_DPAT);
    chk("gap_nvalid", 32'(nv),     32'(3 * NB));
    chk("gap_ready",  32'(nr),     32'd0);
    chk("gap_words",  32'(words3), 32'd3);
    rep = 1'b0;
    repeat (2 * (NB + 3)) tick();
    chk("gap_end_words", 32'(words3), 32'd4);
    chk("gap_end_ready", 32'(ready3), 32'd1);

    // Reset during the 4th bit.
    do_reset();
    din = 8'hFF; load = 1'b1; tick(); load = 1'b0;
    repeat (3) tick();
    chk("mid_valid_before", 32'(valid0), 32'd1);
    r = 1'b1; tick(); r = 1'b0;
    chk("mid_valid", 32'(valid0), 32'd0);
    chk("mid_d",     32'(d0),     32'd0);
    chk("mid_words", 32'(words0), 32'd0);
    chk("mid_ready", 32'(ready0), 32'd1);

    // Busy load ignored; rep beats load at the word end.
    do_reset();
    din = 8'h81; load = 1'b1; tick(); load = 1'b0;
    acc = 0;
    for (int i = 0; i < 2 * NB; i++) begin
      acc = {acc[30:0], d0};
      if (i == 2) begin
        din = 8'h00; load = 1'b1;
      end
      if (i == NB - 1) begin
        rep = 1'b1; load = 1'b1; din = 8'h00;
        #1;
        chk("rep_wins_ready", 32'(ready0), 32'd0);
      end
      tick(); rep = 1'b0; load = 1'b0;
    end
    chk("rep_bits",  acc,         E_REP);
    chk("rep_words", 32'(words0), 32'd2);
    chk("rep_idle",  32'(valid0), 32'd0);

    // Word counter wrap 255 -> 0.
    do_reset();
    rep = 1'b1; din = 8'h5A; load = 1'b1; tick(); load = 1'b0;
    repeat (255 * NB) tick();
    chk("wrap_255", 32'(words0), 32'd255);
    repeat (NB) tick();
    chk("wrap_0", 32'(words0), 32'd0);
    rep = 1'b0;
    repeat (2 * NB + 4) tick();

`ifdef SEQ_GEN_PARITY_EN
    // Parity bit follows the word.
    do_reset();
    din = 8'h07; load = 1'b1; tick(); load = 1'b0;
    acc = 0; nv = 0;
    for (int i = 0; i < NB; i++) begin
      acc = {acc[30:0], d0}; nv += int'(valid0); tick();
    end
    chk("par_bits",   acc,         32'h0000_000F);
    chk("par_nvalid", 32'(nv),     32'd9);
    chk("par_words",  32'(words0), 32'd1);
`endif

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
- Parallel-to-serial stimulus generator.
- Sits directly upstream of the 6-bit serial sequence detector and drives its serial data input d, one bit per clk.
- Accepts WIDTH-bit words over a load/ready handshake and shifts each word out MSB first.
- Supports optional inter-word idle gaps and a repeat mode, so the detector sees continuous streams, including patterns that straddle word boundaries.

Parameters:
- WIDTH, 8, word width in bits (legal range 2..32).
- GAP, 0, idle cycles inserted after each word (legal range 0..15).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- r  input  1  reset; synchronous and active-high (sampled on rising clk, clears all state when 1).
- load  input  1  request to accept din; honoured only when ready=1.
- din  input  WIDTH  word to serialize.
- rep  input  1  repeat mode; sampled at end of each word.
- ready  output  1  generator can accept a word this cycle.
- d  output  1  serial bit to detector.
- valid  output  1  d carries a word bit this cycle.
- words  output  8  count of completed words; wraps 255->0.

Behaviour:
- Reset (r=1 at a rising edge), effective that edge, including mid-word or mid-gap:
  - state=IDLE, shift register=0, saved word=0, bit counter=0, gap counter=0, words=0.
  - Outputs: d=0, valid=0, ready=1.
- States: IDLE, SHIFT, GAP. All outputs are registered, except ready, which is combinational from state and counters.
- IDLE:
  - ready=1, valid=0, d=0.
  - load=1 at an edge: capture din into the shift register and the saved word; go to SHIFT.
  - Latency: the first bit (din[WIDTH-1]) appears on d with valid=1 in the cycle after the accepting edge.
- SHIFT:
  - valid=1 and d=current MSB.
  - Each edge shifts left by 1, zero-fill; the bit counter increments 0..WIDTH-1.
  - After the last bit (counter=WIDTH-1), words increments by 1 and the next state is chosen in priority order:
    - GAP>0: go to GAP with the gap counter at 0.
    - GAP=0 and rep=1: reload the saved word; stay in SHIFT with the counter at 0.
    - GAP=0, rep=0, load=1: accept din back-to-back, with no bubble between words.
    - Otherwise: go to IDLE.
  - ready=1 during SHIFT only in the last-bit cycle, with GAP=0 and rep=0.
- GAP:
  - valid=0, d=0, for exactly GAP cycles.
  - In the final gap cycle, ready=(rep==0). The same priority applies as at the end of SHIFT: rep reloads the saved word; otherwise load is accepted; otherwise go to IDLE.
- load while ready=0: ignored; din is not captured; no error flag.
- rep changes mid-word: no effect until the word-end decision.
- rep=1 and load=1 together at the word end: rep wins; load is ignored and ready=0.
- words counts each word whose last bit was driven; words interrupted by reset are not counted.

Optional Feature:
- Macro: SEQ_GEN_PARITY_EN.
- Defined:
  - Each word is followed by one extra valid=1 bit on d, the even parity of the word: XOR of all WIDTH bits.
  - Words are therefore WIDTH+1 bits long; the gap, repeat, back-to-back rules and ready timing apply after the parity bit; words increments after the parity bit.
- Undefined: no parity bit; the word is exactly WIDTH bits; no parity logic is synthesized.

Test Plan:
- Reset then idle: hold r=1 for 2 cycles then release, no load -> ready=1, valid=0, d=0, words=0 on every cycle.
- Single word (WIDTH=8, GAP=0): load din=8'b1101_0100 -> d=1,1,0,1,0,1,0,0 with valid=1 over 8 cycles starting 1 cycle after acceptance; then IDLE; words=1. The downstream detector flags once, after the 6th bit.
- Back-to-back: load 8'hA5, then hold load=1 with din=8'h3C during the last bit -> 16 consecutive valid=1 bits 10100101 00111100; no bubble; words=2.
- Gap and repeat (GAP=3, rep=1): load 8'hF0 -> pattern of 8 valid bits then 3 idle cycles, repeated; ready=0 throughout; words=3 after 33 cycles.
- Reset mid-word: assert r at the 4th bit of 8'hFF -> next cycle valid=0, d=0, words=0, state=IDLE; the word is not counted.
- Parity (SEQ_GEN_PARITY_EN defined): load 8'b0000_0111 -> bits 00000111 then parity bit 1; 9 valid cycles; words=1.
